// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and constants for the 1-to-16 deserializer
//
// Purpose: word width, the default alignment pattern and the HUNT/LOCKED
// state encoding used by deserializer_1_to_16 and deser_sync_detect.

package deser_pkg;

  localparam int WORD_W = 16;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hF628;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/deser_sync_detect.sv
// rtl/deser_sync_detect.sv - sliding 16-bit window and alignment pattern comparator
//
// Purpose: shifts each qualified serial bit into a 16-bit window and flags the
// cycle on which the updated window equals SYNC_WORD.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - synchronous active-low reset, clears the window
//   bit_in    - serial data bit
//   bit_valid - shift enable (the top gates this to HUNT only)
//   clear     - empties the window; wins over a shift on the same edge
//   match     - combinational, high when the window including this bit is SYNC_WORD

module deser_sync_detect
  import deser_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic clear,
  output logic match
);

  logic [15:0] window;
  logic [15:0] window_next;

  assign window_next = {window[14:0], bit_in};

  // Match looks at the window as it will be after this bit, so the top can
  // change state on the same edge that shifts in the final sync bit.
  assign match = bit_valid && !clear && (window_next == SYNC_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      window <= 16'h0000;
    end else if (clear) begin
      window <= 16'h0000;
    end else if (bit_valid) begin
      window <= window_next;
    end
  end

endmodule

// File: rtl/deserializer_1_to_16.sv
// rtl/deserializer_1_to_16.sv - serial to 16-bit word deserializer with sync-word alignment
//
// Purpose: assembles MSB-first serial bits into 16-bit words. With
// DESER_SYNC_EN defined the block hunts for SYNC_WORD before locking onto
// word boundaries; without it the block is locked from reset and the first
// valid bit after reset starts word 0.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset
//   bit_in     - serial data, MSB first
//   bit_valid  - bit_in qualifier
//   realign    - one-cycle request to drop lock and re-hunt
//   data_out   - assembled word, first received bit at [15]
//   data_valid - data_out holds an unconsumed word
//   data_ready - consumer accept
//   locked     - FSM is in LOCKED
//   overrun    - sticky, a word was overwritten before it was accepted

module deserializer_1_to_16
  import deser_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEFAULT,
  parameter int          WORD_W    = deser_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              realign,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              locked,
  output logic              overrun
);

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        bit_cnt;
  logic [WORD_W-1:0] asm_q;
  logic [WORD_W-1:0] word_next;
  logic              sync_match;
  logic              word_done;
  logic              transfer;

`ifdef DESER_SYNC_EN
  localparam state_t RESET_STATE = HUNT;

  deser_sync_detect #(
    .SYNC_WORD (SYNC_WORD)
  ) u_sync_detect (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_valid (bit_valid && (state_q == HUNT)),
    .clear     (realign),
    .match     (sync_match)
  );
`else
  localparam state_t RESET_STATE = LOCKED;

  // Alignment pattern has no role when the block is always locked.
  logic unused_sync_cfg;
  assign unused_sync_cfg = ^SYNC_WORD;
  assign sync_match      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (!realign && sync_match) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (realign) begin
          state_d = RESET_STATE;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign locked    = (state_q == LOCKED);
  assign word_next = {asm_q[WORD_W-2:0], bit_in};
  assign transfer  = data_valid && data_ready;

  // Realign wins over the bit that would have completed a word.
  assign word_done = (state_q == LOCKED) && bit_valid && !realign &&
                     (bit_cnt == 4'(WORD_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      asm_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (realign) begin
        bit_cnt <= 4'd0;
        overrun <= 1'b0;
      end else if ((state_q == LOCKED) && bit_valid) begin
        asm_q   <= word_next;
        bit_cnt <= bit_cnt + 4'd1;
      end else if ((state_q == HUNT) && sync_match) begin
        bit_cnt <= 4'd0;
      end

      // A word landing on the accept edge keeps data_valid high with the new word.
      if (word_done) begin
        data_out   <= word_next;
        data_valid <= 1'b1;
        if (data_valid && !data_ready) begin
          overrun <= 1'b1;
        end
      end else if (transfer) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_deserializer_1_to_16.sv
// tb/tb_deserializer_1_to_16.sv - self-checking bench for deserializer_1_to_16

module tb_deserializer_1_to_16;

`ifdef DESER_SYNC_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif
  localparam logic [15:0] SYNC = 16'hF628;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in;
  logic        bit_valid;
  logic        realign;
  logic        data_ready;
  logic [15:0] data_out;
  logic        data_valid;
  logic        locked;
  logic        overrun;

  always #5 clk = ~clk;

  deserializer_1_to_16 #(
    .SYNC_WORD (16'hF628),
    .WORD_W    (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .realign    (realign),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .locked     (locked),
    .overrun    (overrun)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model: bit history while hunting, a queue of bits while locked.
  bit          m_locked;
  int          m_hist;
  bit          m_bits[$];
  logic [15:0] m_do;
  bit          m_dv;
  bit          m_ovr;

  int          deliveries;
  logic [15:0] last_del;
  logic [15:0] prev_del;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_locked = !SYNC_EN;
    m_hist   = 0;
    m_bits.delete();
    m_do     = 16'h0000;
    m_dv     = 1'b0;
    m_ovr    = 1'b0;
  endtask

  task automatic model_edge(input bit b, input bit v, input bit rd, input bit ra, input bit rs);
    bit          xfer;
    bit          loaded;
    logic [15:0] w;
    if (!rs) begin
      model_reset();
      return;
    end
    xfer   = m_dv && rd;
    loaded = 1'b0;
    if (ra) begin
      m_locked = !SYNC_EN;
      m_hist   = 0;
      m_bits.delete();
      m_ovr    = 1'b0;
    end else if (v) begin
      if (!m_locked) begin
        m_hist = (m_hist * 2 + int'(b)) % 65536;
        if (m_hist == int'(SYNC)) begin
          m_locked = 1'b1;
          m_bits.delete();
        end
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == 16) begin
          w = 16'h0000;
          foreach (m_bits[i]) w = w * 2 + 16'(m_bits[i]);
          m_bits.delete();
          if (m_dv && !rd) m_ovr = 1'b1;
          m_do   = w;
          m_dv   = 1'b1;
          loaded = 1'b1;
        end
      end
    end
    if (xfer && !loaded) m_dv = 1'b0;
  endtask

  task automatic step(input bit b, input bit v, input bit rd, input bit ra, input bit rs);
    bit_in     = b;
    bit_valid  = v;
    data_ready = rd;
    realign    = ra;
    rst_n      = rs;
    if (rs && rd && data_valid) begin
      deliveries++;
      prev_del = last_del;
      last_del = data_out;
    end
    @(posedge clk);
    model_edge(b, v, rd, ra, rs);
    #1;
    check("data_out", 32'(data_out), 32'(m_do));
    check("data_valid", 32'(data_valid), 32'(m_dv));
    check("locked", 32'(locked), 32'(m_locked));
    check("overrun", 32'(overrun), 32'(m_ovr));
  endtask

  task automatic idle(input int n, input bit rd);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b0, rd, 1'b0, 1'b1);
  endtask

  task automatic send_word(input logic [15:0] w, input bit rd, input bit gaps);
    for (int i = 15; i >= 0; i--) begin
      if (gaps) step(1'($urandom), 1'b0, rd, 1'b0, 1'b1);
      step(w[i], 1'b1, rd, 1'b0, 1'b1);
    end
  endtask

  initial begin
    int n;
    int base;
    logic [15:0] rw;
    model_reset();
    deliveries = 0;
    last_del   = 16'h0000;
    prev_del   = 16'h0000;
    bit_in = 1'b0; bit_valid = 1'b0; realign = 1'b0; data_ready = 1'b0; rst_n = 1'b0;

    // Reset, then idle.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0);
    check("idle_data_out", 32'(data_out), 32'h0);
    check("idle_locked", 32'(locked), 32'(!SYNC_EN));

    // Random prefix, then sync and A5C3 back to back.
    n = $urandom_range(5, 40);
    for (int i = 0; i < n; i++) step(1'($urandom), 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    check("locked_after_sync", 32'(locked), 32'h1);
    send_word(16'hA5C3, 1'b1, 1'b0);
    check("a5c3_valid", 32'(data_valid), 32'h1);
    check("a5c3_data", 32'(data_out), 32'hA5C3);
    idle(1, 1'b1);
    check("a5c3_consumed", 32'(data_valid), 32'h0);

    // Overrun with consumer stalled.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b0, 1'b0);
    send_word(16'h1234, 1'b0, 1'b0);
    send_word(16'h5678, 1'b0, 1'b0);
    check("ovr_data", 32'(data_out), 32'h5678);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    idle(3, 1'b0);
    check("ovr_sticky", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("ovr_cleared", 32'(overrun), 32'h0);

    // Gapped bits.
    send_word(SYNC, 1'b1, 1'b1);
    send_word(16'hBEEF, 1'b1, 1'b1);
    check("gap_data", 32'(data_out), 32'hBEEF);
    check("gap_valid", 32'(data_valid), 32'h1);
    idle(2, 1'b1);

    // Reset mid-word discards the partial word.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    for (int i = 15; i >= 9; i--) step(1'(16'hFFFF >> i), 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rst_valid", 32'(data_valid), 32'h0);
    deliveries = 0;
    idle(4, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    send_word(16'h0F0F, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("rst_deliveries", 32'(deliveries), SYNC_EN ? 32'd1 : 32'd2);
    check("rst_last", 32'(last_del), 32'h0F0F);

    // Realign mid-word, then loopback of 0001 and 8000.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    base = deliveries;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("realign_locked", 32'(locked), 32'(!SYNC_EN));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1, 1'b1);
    check("realign_no_word", 32'(deliveries - base), SYNC_EN ? 32'd0 : 32'd2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    send_word(16'h0001, 1'b1, 1'b0);
    send_word(16'h8000, 1'b1, 1'b0);
    idle(1, 1'b1);
    check("loop_first", 32'(prev_del), 32'h0001);
    check("loop_second", 32'(last_del), 32'h8000);

    // Randomized words with random gaps and consumer stalls.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_word(SYNC, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      rw = 16'($urandom);
      for (int i = 15; i >= 0; i--) begin
        while ($urandom_range(0, 3) == 0) step(1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b1);
        step(rw[i], 1'b1, 1'($urandom), 1'b0, 1'b1);
      end
    end
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
